sipo_msb_rx: RTL

//  Serial-in/parallel-out frame receiver; counterpart of the MSB-first PISO transmitter.

---
 rtl/sipo_rx_pkg.sv | 14 +
 rtl/sipo_msb_rx_sync_2ff.sv | 25 ++
 rtl/sipo_msb_rx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and default sizing for the MSB-first serial frame receiver.
package sipo_rx_pkg;

   localparam int DW_DEF           = 10;
   localparam int CLKS_PER_BIT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/sipo_msb_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic enb,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else if (enb) begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/sipo_msb_rx.sv
// Oversampling serial-in/parallel-out receiver: start bit, DW data bits MSB first, stop bit.
module sipo_msb_rx
   import sipo_rx_pkg::*;
#(
   parameter int DW           = DW_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enb,
   input  logic          inp,
   output logic [DW-1:0] data_out,
   output logic          valid,
   output logic          frame_err,
   output logic          busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DW + 1);

   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DW - 1);

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] bit_idx_q, bit_idx_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          rx_s;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .enb   (enb),
      .d     (inp),
      .q     (rx_s)
   );

   // NOTE: combinational next-state uses blocking '=' with every target defaulted first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = ferr_q;
      if (enb) begin
         valid_d = 1'b0;
         ferr_d  = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_d     = '0;
                  bit_idx_d = '0;
                  state_d   = rx_s ? IDLE : DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == LAST_CNT) begin
                  shreg_d   = {shreg_q[DW-2:0], rx_s};
                  cnt_d     = '0;
                  bit_idx_d = bit_idx_q + 1'b1;
                  if (bit_idx_q == LAST_BIT) state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  if (rx_s) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A pulse raised just before enb drops is held here and released once enb returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q & enb;
   assign frame_err = ferr_q & enb;
   assign busy      = (state_q != IDLE);

endmodule
